// File: rtl/acc_drain_fifo.sv
// acc_drain_fifo: read-side companion to the 16-bit accumulator register.
// Captures every value the CPU writes into the accumulator and buffers it in a
// small FIFO. A downstream consumer drains the FIFO through a valid/ready
// handshake. The block never stalls the CPU. A write that arrives while the
// FIFO is full is discarded and recorded in the sticky overflow flag.
//
// All state changes on the falling edge of clk, matching the accumulator.
//
// Optional feature: define ACC_DRAIN_OVF_CNT_EN to add an 8-bit saturating
// drop counter on port drop_cnt. In that build, overflow is derived from the
// counter.
//
// DEPTH must be a power of two (minimum 2). CNT_W must be log2(DEPTH)+1.
module acc_drain_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              full,
    output logic [CNT_W-1:0]  count,
`ifdef ACC_DRAIN_OVF_CNT_EN
    output logic              overflow,
    output logic [7:0]        drop_cnt
`else
    output logic              overflow
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W-1:0]  wptr;
    logic              pop;
    logic              push;
    logic              drop;

    // Handshake decode. A pop at full frees a slot, so a push on the same
    // edge is still accepted. Pops need out_valid, so an empty FIFO never
    // bypasses a push straight through to the consumer.
    always_comb begin
        out_valid = (count != '0);
        full      = (count == CNT_W'(DEPTH));
        pop       = out_valid && out_ready;
        push      = wr_en && (!full || pop);
        drop      = wr_en && full && !pop;
        out       = out_valid ? mem[rptr] : '0;
    end

    // Storage, pointers and occupancy. Pointers wrap naturally because DEPTH
    // is a power of two. Reset clears every entry, so no stale data survives.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= in;
                wptr      <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef ACC_DRAIN_OVF_CNT_EN
    // Saturating count of dropped writes. The counter is cleared only by reset.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= 8'd0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign overflow = (drop_cnt != 8'd0);
`else
    // Sticky drop indicator. It is set on the first discarded write and held
    // until reset.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_acc_drain_fifo.sv
// Directed self-checking bench for acc_drain_fifo.
// Inputs are driven just after the rising edge. The DUT updates on the falling
// edge. Outputs are sampled one time unit after the following rising edge.
module tb_acc_drain_fifo;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [15:0] in;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic        full;
    logic [2:0]  count;
    logic        overflow;
`ifdef ACC_DRAIN_OVF_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int checks;
    int errors;

    acc_drain_fifo #(.DATA_W(16), .DEPTH(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .in        (in),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .count     (count),
`ifdef ACC_DRAIN_OVF_CNT_EN
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
`else
        .overflow  (overflow)
`endif
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one set of inputs across a single falling edge, then settle after
    // the next rising edge.
    task automatic applyStimulus(input logic w, input logic [15:0] d, input logic r);
        wr_en     = w;
        in        = d;
        out_ready = r;
        @(negedge clk);
        @(posedge clk);
        #1;
        wr_en     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic fillFour();
        applyStimulus(1'b1, 16'h1111, 1'b0);
        applyStimulus(1'b1, 16'h2222, 1'b0);
        applyStimulus(1'b1, 16'h3333, 1'b0);
        applyStimulus(1'b1, 16'h4444, 1'b0);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        wr_en     = 1'b0;
        in        = 16'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out",      32'(out), 0);
        checkOutput("rst_valid",    32'(out_valid), 0);
        checkOutput("rst_count",    32'(count), 0);
        checkOutput("rst_full",     32'(full), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        // Writes and ready requests must be ignored while reset is held.
        applyStimulus(1'b1, 16'hBEEF, 1'b1);
        checkOutput("rst_hold_count", 32'(count), 0);
        rst = 1'b0;

        // A push into an empty FIFO must not pop on the same edge.
        applyStimulus(1'b1, 16'h7777, 1'b1);
        checkOutput("nobypass_count", 32'(count), 1);
        checkOutput("nobypass_out",   32'(out), 32'h7777);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("nobypass_drain", 32'(count), 0);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("empty_ready_count", 32'(count), 0);

        // Fill the FIFO in order, then drain it.
        applyStimulus(1'b1, 16'h1111, 1'b0);
        checkOutput("latency_valid", 32'(out_valid), 1);
        checkOutput("latency_out",   32'(out), 32'h1111);
        applyStimulus(1'b1, 16'h2222, 1'b0);
        applyStimulus(1'b1, 16'h3333, 1'b0);
        applyStimulus(1'b1, 16'h4444, 1'b0);
        checkOutput("fill_count", 32'(count), 4);
        checkOutput("fill_full",  32'(full), 1);
        checkOutput("fill_out",   32'(out), 32'h1111);
        applyStimulus(1'b0, 16'h0, 1'b0);
        checkOutput("hold_out", 32'(out), 32'h1111);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("drain1_out", 32'(out), 32'h2222);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("drain2_out", 32'(out), 32'h3333);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("drain3_out", 32'(out), 32'h4444);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("drain_count", 32'(count), 0);
        checkOutput("drain_valid", 32'(out_valid), 0);
        checkOutput("drain_out",   32'(out), 0);

        // At full, a simultaneous push and pop are both accepted.
        fillFour();
        applyStimulus(1'b1, 16'hAAAA, 1'b1);
        checkOutput("pp_count", 32'(count), 4);
        checkOutput("pp_full",  32'(full), 1);
        checkOutput("pp_out",   32'(out), 32'h2222);
        checkOutput("pp_overflow", 32'(overflow), 0);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("pp_d1", 32'(out), 32'h3333);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("pp_d2", 32'(out), 32'h4444);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("pp_d3", 32'(out), 32'hAAAA);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("pp_empty", 32'(count), 0);
        checkOutput("pp_overflow_end", 32'(overflow), 0);

        // A push at full with no pop is dropped.
        fillFour();
        applyStimulus(1'b1, 16'h5555, 1'b0);
        checkOutput("drop_count",    32'(count), 4);
        checkOutput("drop_out",      32'(out), 32'h1111);
        checkOutput("drop_overflow", 32'(overflow), 1);
`ifdef ACC_DRAIN_OVF_CNT_EN
        checkOutput("drop_cnt_1", 32'(drop_cnt), 1);
`endif
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("drop_d1", 32'(out), 32'h2222);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("drop_d2", 32'(out), 32'h3333);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("drop_d3", 32'(out), 32'h4444);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("drop_empty_valid", 32'(out_valid), 0);
        checkOutput("drop_empty_out",   32'(out), 0);
        checkOutput("drop_sticky",      32'(overflow), 1);

        // Continuous push and pop across the wrap of both pointers.
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) begin
                checkOutput($sformatf("wrap_pop%0d", i - 1), 32'(out), 32'(i - 1));
            end
            applyStimulus(1'b1, 16'(i), 1'b1);
        end
        checkOutput("wrap_count", 32'(count), 1);
        checkOutput("wrap_out",   32'(out), 32'h000A);

        // Reset is asserted between edges while data is stored.
        applyStimulus(1'b1, 16'h0B0B, 1'b0);
        checkOutput("pre_rst_count", 32'(count), 2);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_out",      32'(out), 0);
        checkOutput("async_rst_valid",    32'(out_valid), 0);
        checkOutput("async_rst_count",    32'(count), 0);
        checkOutput("async_rst_full",     32'(full), 0);
        checkOutput("async_rst_overflow", 32'(overflow), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 16'hC0DE, 1'b1);
        checkOutput("post_rst_count", 32'(count), 1);
        checkOutput("post_rst_out",   32'(out), 32'hC0DE);

`ifdef ACC_DRAIN_OVF_CNT_EN
        // The drop counter saturates at 255 and is cleared by reset.
        pulseReset();
        fillFour();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 16'h5A5A, 1'b0);
        end
        checkOutput("sat_drop_cnt", 32'(drop_cnt), 255);
        checkOutput("sat_overflow", 32'(overflow), 1);
        checkOutput("sat_out",      32'(out), 32'h1111);
        rst = 1'b1;
        #1;
        checkOutput("sat_rst_cnt", 32'(drop_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
